// File: rtl/fpcmult_iter_sat.sv
// rtl/fpcmult_iter_sat.sv - iterative fixed-point complex multiplier, three-product form, wrap/saturate
module fpcmult_iter_sat #(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  input  logic         conj,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         ovf
);

  localparam int N1 = n + 1;
  localparam int W  = 2 * n + 2;
  localparam int RW = 2 * n + 4;
  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(n);
  localparam logic signed [RW-1:0] MAXV = {{(RW-n+1){1'b0}}, {(n-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-n+1){1'b1}}, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [N1-1:0]  ac_q, ac_d, bcj_q, bcj_d, sa_q, sa_d, sb_q, sb_d;
  logic signed [N1-1:0]  mplier_q, mplier_d;
  logic signed [W-1:0]   mcand_q, mcand_d, acc_q, acc_d, p1_q, p1_d, p2_q, p2_d;
  logic [n-1:0]          cr_q, cr_d, cc_q, cc_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic signed [N1-1:0]  ar_x, ac_x, br_x, bc_x, bcj_x, sa_x, sb_x;
  logic signed [W-1:0]   pp, acc_nx, prod_sh;
  logic signed [RW-1:0]  p1_x, p2_x, p3_x, rr, rc;
  logic                  ovf_r;

  function automatic logic signed [W-1:0] ext_w(input logic signed [N1-1:0] x);
    return {{(W-N1){x[N1-1]}}, x};
  endfunction

  function automatic logic [n-1:0] fit(input logic signed [RW-1:0] v);
    if (SAT && (v > MAXV)) return MAXV[n-1:0];
    if (SAT && (v < MINV)) return MINV[n-1:0];
    return v[n-1:0];
  endfunction

  assign ar_x  = {ar[n-1], ar};
  assign ac_x  = {ac[n-1], ac};
  assign br_x  = {br[n-1], br};
  assign bc_x  = {bc[n-1], bc};
  assign bcj_x = conj ? -bc_x : bc_x;
  assign sa_x  = ar_x + ac_x;
  assign sb_x  = br_x + bcj_x;

  // Serial signed multiply: the multiplier MSB carries negative weight, so its step subtracts.
  assign pp      = !mplier_q[0] ? '0 : ((cnt_q == CNT_LAST) ? -mcand_q : mcand_q);
  assign acc_nx  = acc_q + pp;
  assign prod_sh = acc_nx >>> d;

  assign p1_x  = {{(RW-W){p1_q[W-1]}}, p1_q};
  assign p2_x  = {{(RW-W){p2_q[W-1]}}, p2_q};
  assign p3_x  = {{(RW-W){prod_sh[W-1]}}, prod_sh};
  assign rr    = p1_x - p2_x;
  assign rc    = p3_x - p1_x - p2_x;
  assign ovf_r = (rr > MAXV) || (rr < MINV) || (rc > MAXV) || (rc < MINV);

  always_comb begin
    recv_rdy = 1'b0;
    case (state_q)
      IDLE:    recv_rdy = 1'b1;
      DONE:    recv_rdy = send_rdy;
      default: recv_rdy = 1'b0;
    endcase
  end

  assign accept   = recv_val && recv_rdy;
  assign send_val = (state_q == DONE);
  assign cr       = cr_q;
  assign cc       = cc_q;
  assign ovf      = ovf_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    ac_d     = ac_q;
    bcj_d    = bcj_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    cr_d     = cr_q;
    cc_d     = cc_q;
    ovf_d    = ovf_q;

    case (state_q)
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >>> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          acc_d = '0;
          case (k_q)
            2'd0: begin
              p1_d     = prod_sh;
              mcand_d  = ext_w(ac_q);
              mplier_d = bcj_q;
              k_d      = 2'd1;
            end
            2'd1: begin
              p2_d     = prod_sh;
              mcand_d  = ext_w(sa_q);
              mplier_d = sb_q;
              k_d      = 2'd2;
            end
            default: begin
              cr_d    = fit(rr);
              cc_d    = fit(rc);
              ovf_d   = ovf_r;
              state_d = DONE;
            end
          endcase
        end
      end
      DONE: begin
        if (send_rdy) state_d = IDLE;
      end
      default: ;
    endcase

    // Only reachable from IDLE or DONE, since recv_rdy is low during MUL.
    if (accept) begin
      state_d  = MUL;
      k_d      = 2'd0;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = ext_w(ar_x);
      mplier_d = br_x;
      ac_d     = ac_x;
      bcj_d    = bcj_x;
      sa_d     = sa_x;
      sb_d     = sb_x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      ac_q     <= '0;
      bcj_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      cr_q     <= '0;
      cc_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      ac_q     <= ac_d;
      bcj_q    <= bcj_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      cr_q     <= cr_d;
      cc_q     <= cc_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fpcmult_iter_sat.sv
// tb/tb_fpcmult_iter_sat.sv - directed-vector bench for fpcmult_iter_sat, wrap and saturate instances
module tb_fpcmult_iter_sat;

  localparam int N   = 32;
  localparam int D   = 16;
  localparam int LAT = 3 * (N + 1) + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         recv_val;
  logic         send_rdy;
  logic         conj;
  logic [N-1:0] ar, ac, br, bc;
  logic         recv_rdy_w, send_val_w, ovf_w;
  logic         recv_rdy_s, send_val_s, ovf_s;
  logic [N-1:0] cr_w, cc_w, cr_s, cc_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpcmult_iter_sat #(.n(N), .d(D), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy_w),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .conj(conj),
    .send_val(send_val_w), .send_rdy(send_rdy), .cr(cr_w), .cc(cc_w), .ovf(ovf_w)
  );

  fpcmult_iter_sat #(.n(N), .d(D), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy_s),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .conj(conj),
    .send_val(send_val_s), .send_rdy(send_rdy), .cr(cr_s), .cc(cc_s), .ovf(ovf_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load_ops(input logic [31:0] a_r, a_c, b_r, b_c, input logic cj);
    ar = a_r; ac = a_c; br = b_r; bc = b_c; conj = cj;
  endtask

  task automatic accept_op(input logic [31:0] a_r, a_c, b_r, b_c, input logic cj);
    load_ops(a_r, a_c, b_r, b_c, cj);
    recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
  endtask

  // lat counts clock edges from the accept edge (inclusive) to the first cycle with send_val high.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!send_val_w && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a_r, a_c, b_r, b_c, input logic cj,
                         input logic [31:0] ecr_w, ecc_w, ecr_s, ecc_s, input logic eovf);
    int lat;
    check({tag, ".rdy"}, 32'(recv_rdy_w), 32'd1);
    accept_op(a_r, a_c, b_r, b_c, cj);
    wait_done(lat);
    check({tag, ".lat"}, 32'(lat), 32'(LAT));
    check({tag, ".val_s"}, 32'(send_val_s), 32'd1);
    check({tag, ".cr_w"}, cr_w, ecr_w);
    check({tag, ".cc_w"}, cc_w, ecc_w);
    check({tag, ".ovf_w"}, 32'(ovf_w), 32'(eovf));
    check({tag, ".cr_s"}, cr_s, ecr_s);
    check({tag, ".cc_s"}, cc_s, ecc_s);
    check({tag, ".ovf_s"}, 32'(ovf_s), 32'(eovf));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit seen;
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b1;
    load_ops(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst.rdy", 32'(recv_rdy_w), 32'd1);
    check("rst.val", 32'(send_val_w), 32'd0);
    check("rst.cr", cr_w, 32'h0);
    check("rst.cc", cc_w, 32'h0);
    check("rst.ovf", 32'(ovf_w), 32'd0);

    run_vec("basic", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
            32'hFFFB0000, 32'h000A0000, 32'hFFFB0000, 32'h000A0000, 1'b0);
    run_vec("conj", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
            32'h000B0000, 32'h00020000, 32'h000B0000, 32'h00020000, 1'b0);
    run_vec("frac", 32'hFFFF8000, 32'h00004000, 32'h00008000, 32'h00000000, 1'b0,
            32'hFFFFC000, 32'h00002000, 32'hFFFFC000, 32'h00002000, 1'b0);
    run_vec("floor_pos", 32'h00000001, 32'h00000000, 32'h00008000, 32'h00000000, 1'b0,
            32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
    run_vec("floor_neg", 32'hFFFFFFFF, 32'h00000000, 32'h00008000, 32'h00000000, 1'b0,
            32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_vec("ovf_pos", 32'h7FFF0000, 32'h00000000, 32'h00020000, 32'h00000000, 1'b0,
            32'hFFFE0000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b1);
    run_vec("ovf_edge", 32'h40000000, 32'h00000000, 32'h00020000, 32'h00000000, 1'b0,
            32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b1);
    run_vec("ovf_neg", 32'h80000000, 32'h00000000, 32'h00020000, 32'h00000000, 1'b0,
            32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 1'b1);
    run_vec("min_fit", 32'h00000000, 32'h00010000, 32'h00000000, 32'h80000000, 1'b1,
            32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    run_vec("min_ovf", 32'h00000000, 32'h00010000, 32'h00000000, 32'h80000000, 1'b0,
            32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b1);

    send_rdy = 1'b0;
    accept_op(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0);
    wait_done(lat);
    check("hold.lat", 32'(lat), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold.val", 32'(send_val_w), 32'd1);
      check("hold.rdy", 32'(recv_rdy_w), 32'd0);
      check("hold.cr", cr_w, 32'hFFFB0000);
      check("hold.cc", cc_w, 32'h000A0000);
    end
    load_ops(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1);
    recv_val = 1'b1;
    send_rdy = 1'b1;
    #1;
    check("b2b.rdy", 32'(recv_rdy_w), 32'd1);
    @(posedge clk); #1;
    recv_val = 1'b0;
    check("b2b.val_lo", 32'(send_val_w), 32'd0);
    check("b2b.rdy_lo", 32'(recv_rdy_w), 32'd0);
    check("b2b.cr_hold", cr_w, 32'hFFFB0000);
    wait_done(lat);
    check("b2b.lat", 32'(lat), 32'(LAT));
    check("b2b.cr", cr_w, 32'h000B0000);
    check("b2b.cc", cc_w, 32'h00020000);
    @(posedge clk); #1;

    accept_op(32'h7FFF0000, 32'h00000000, 32'h00020000, 32'h00000000, 1'b0);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (send_val_w || send_val_s) seen = 1'b1;
    end
    check("abort.val", 32'(seen), 32'd0);
    check("abort.cr", cr_w, 32'h0);
    check("abort.cc", cc_w, 32'h0);
    check("abort.ovf", 32'(ovf_w), 32'd0);
    check("abort.cr_s", cr_s, 32'h0);
    check("abort.rdy", 32'(recv_rdy_w), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
